// File: rtl/voltmeter_pkg.sv
// Shared voltmeter constants: FSM state codes, default phase lengths, AFE select encodings.
// Pure declarations; no timing or flow-control behaviour.
package voltmeter_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_AZ    = 3'd1;
    localparam logic [2:0] ST_INT   = 3'd2;
    localparam logic [2:0] ST_DEINT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int T_AZ_DEF      = 256;
    localparam int T_INT_DEF     = 1000;
    localparam int CNT_W_DEF     = 16;
    localparam int DEINT_MAX_DEF = 2000;

    localparam logic AFE_SEL_INPUT = 1'b0;
    localparam logic AFE_SEL_REF   = 1'b1;

    // Integrator is held in reset whenever it is not actively integrating.
    function automatic logic afe_reset_for(input logic [2:0] st);
        return (st == ST_IDLE) || (st == ST_AZ) || (st == ST_DONE);
    endfunction

    function automatic logic afe_sel_for(input logic [2:0] st);
        return (st == ST_DEINT) ? AFE_SEL_REF : AFE_SEL_INPUT;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous status bits.
// Latency 2 clk_i cycles; no backpressure.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dual_slope_ctrl.sv
// Dual-slope AFE sequencer: auto-zero, fixed integrate, timed de-integrate, signed-magnitude result.
// Status inputs seen 2 cycles late (uncompensated); start_i ignored while busy, no other backpressure.
module dual_slope_ctrl
    import voltmeter_pkg::*;
#(
    parameter int T_AZ      = T_AZ_DEF,
    parameter int T_INT     = T_INT_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DEINT_MAX = DEINT_MAX_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic             range_i,
    input  logic             comp_i,
    input  logic             sat_hi_i,
    input  logic             sat_lo_i,
    input  logic             ref_ok_i,
    output logic             afe_sel_o,
    output logic             afe_reset_o,
    output logic             ref_sign_o,
    output logic             range_sel_o,
    output logic             busy_o,
    output logic             result_valid_o,
    output logic [CNT_W-1:0] result_o,
    output logic             polarity_o,
    output logic             overrange_o,
    output logic             error_o
);

    localparam int PH_MAX0 = (T_AZ > T_INT) ? T_AZ : T_INT;
    localparam int PH_MAX  = (PH_MAX0 > DEINT_MAX) ? PH_MAX0 : DEINT_MAX;
    localparam int PH_W    = $clog2(PH_MAX + 1);

    logic [3:0] stat_s;
    logic       comp_s;
    logic       sat_s;
    logic       ref_ok_s;

    sync_2ff #(.W(4)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   ({ref_ok_i, sat_lo_i, sat_hi_i, comp_i}),
        .q_o   (stat_s)
    );

    assign comp_s   = stat_s[0];
    assign sat_s    = stat_s[1] | stat_s[2];
    assign ref_ok_s = stat_s[3];

    logic [2:0]       state_q,     state_d;
    logic [PH_W-1:0]  ph_cnt_q,    ph_cnt_d;
    logic             pol_ref_q,   pol_ref_d;
    logic             ovr_q,       ovr_d;
    logic             err_q,       err_d;
    logic [CNT_W-1:0] result_q,    result_d;
    logic             polarity_q,  polarity_d;
    logic             ref_sign_q,  ref_sign_d;
    logic             range_q,     range_d;
    logic             overrange_q, overrange_d;
    logic             error_q,     error_d;
    logic             afe_reset_q, afe_sel_q, busy_q, valid_q;

    always_comb begin
        state_d     = state_q;
        ph_cnt_d    = ph_cnt_q + PH_W'(1);
        pol_ref_d   = pol_ref_q;
        ovr_d       = ovr_q;
        err_d       = err_q;
        result_d    = result_q;
        polarity_d  = polarity_q;
        ref_sign_d  = ref_sign_q;
        range_d     = range_q;
        overrange_d = overrange_q;
        error_d     = error_q;

        case (state_q)
            ST_IDLE: begin
                ph_cnt_d = '0;
                if (start_i) begin
                    if (!ref_ok_s) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        range_d = range_i;
                        ovr_d   = 1'b0;
                        err_d   = 1'b0;
                        state_d = ST_AZ;
                    end
                end
            end
            ST_AZ: begin
                if (ph_cnt_q == PH_W'(T_AZ - 1)) state_d = ST_INT;
            end
            ST_INT: begin
                if (sat_s) ovr_d = 1'b1;
                if (ph_cnt_q == PH_W'(T_INT - 1)) begin
                    pol_ref_d  = comp_s;
                    ref_sign_d = comp_s;
                    polarity_d = ~comp_s;
                    state_d    = ST_DEINT;
                end
            end
            ST_DEINT: begin
                // Count equals cycles spent de-integrating before the crossing was seen.
                if (comp_s != pol_ref_q) begin
                    result_d = CNT_W'(ph_cnt_q);
                    state_d  = ST_DONE;
                end else if (ph_cnt_q == PH_W'(DEINT_MAX)) begin
                    result_d = CNT_W'(DEINT_MAX);
                    ovr_d    = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cont_i && !error_q) begin
                    range_d = range_i;
                    ovr_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_AZ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (((state_q == ST_AZ) || (state_q == ST_INT) || (state_q == ST_DEINT)) && !ref_ok_s) begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = ST_DONE;
        end

        if (state_d != state_q) ph_cnt_d = '0;

        // Visible flags only change as a result is published.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            overrange_d = ovr_d;
            error_d     = err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ph_cnt_q    <= '0;
            pol_ref_q   <= 1'b0;
            ovr_q       <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            polarity_q  <= 1'b0;
            ref_sign_q  <= 1'b0;
            range_q     <= 1'b0;
            overrange_q <= 1'b0;
            error_q     <= 1'b0;
            afe_reset_q <= 1'b1;
            afe_sel_q   <= AFE_SEL_INPUT;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_cnt_q    <= ph_cnt_d;
            pol_ref_q   <= pol_ref_d;
            ovr_q       <= ovr_d;
            err_q       <= err_d;
            result_q    <= result_d;
            polarity_q  <= polarity_d;
            ref_sign_q  <= ref_sign_d;
            range_q     <= range_d;
            overrange_q <= overrange_d;
            error_q     <= error_d;
            afe_reset_q <= afe_reset_for(state_d);
            afe_sel_q   <= afe_sel_for(state_d);
            busy_q      <= (state_d != ST_IDLE);
            valid_q     <= (state_d == ST_DONE);
        end
    end

    assign afe_sel_o      = afe_sel_q;
    assign afe_reset_o    = afe_reset_q;
    assign ref_sign_o     = ref_sign_q;
    assign range_sel_o    = range_q;
    assign busy_o         = busy_q;
    assign result_valid_o = valid_q;
    assign result_o       = result_q;
    assign polarity_o     = polarity_q;
    assign overrange_o    = overrange_q;
    assign error_o        = error_q;

endmodule
